mac_drain: RTL

MAC_DRAIN -- requirements
Module: mac_drain

---
 rtl/nn_pkg.sv | 16 +
 rtl/lane_clamp.sv | 35 +++
 rtl/mac_drain.sv | 130 +++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the quantised MAC datapath.
package nn_pkg;

  localparam int LANES    = 28;
  localparam int ACC_W    = 32;
  localparam int Q_W      = 8;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;
  localparam int SAT_W    = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/lane_clamp.sv
// One lane of the requantiser: optional ReLU, zero-point add, int8 clamp.
module lane_clamp
  import nn_pkg::*;
#(
  parameter int ZP      = 0,
  parameter int RELU_EN = 1
) (
  input  logic [ACC_W-1:0] i_pq,
  output logic [Q_W-1:0]   o_q,
  output logic             o_sat
);

  // One extra bit of headroom so the zero-point add can never wrap.
  logic signed [ACC_W:0] w_v;
  logic signed [ACC_W:0] w_w;

  // ReLU, zero-point add, then saturate to the int8 range.
  always_comb begin
    w_v = {i_pq[ACC_W-1], i_pq};
    if ((RELU_EN != 0) && i_pq[ACC_W-1]) begin
      w_v = '0;
    end
    w_w   = w_v + (ACC_W+1)'(ZP);
    o_q   = w_w[Q_W-1:0];
    o_sat = 1'b0;
    if (w_w > (ACC_W+1)'(INT8_MAX)) begin
      o_q   = Q_W'(INT8_MAX);
      o_sat = 1'b1;
    end else if (w_w < (ACC_W+1)'(INT8_MIN)) begin
      o_q   = Q_W'(INT8_MIN);
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/mac_drain.sv
// Captures one vector of MAC results, requantises every lane in parallel
// into a flop buffer, then streams the int8 lanes out one beat per handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. cap_ready depends only on state, never on cap_valid; out_valid and
// out_data depend only on registered state, never on out_ready. While a beat
// is offered and not taken, out_data/out_last hold stable.
module mac_drain
  import nn_pkg::*;
#(
  parameter int LANES   = nn_pkg::LANES,
  parameter int ZP      = 0,
  parameter int RELU_EN = 1
) (
  input  logic                   clk,
  input  logic                   main_rst_n,
  input  logic                   drain_clr,
  input  logic [ACC_W*LANES-1:0] pq_vec,
  input  logic                   cap_valid,
  output logic                   cap_ready,
  output logic [Q_W-1:0]         out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   done,
  output logic [SAT_W-1:0]       sat_count
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [Q_W-1:0]     r_buf [LANES];
  logic [SAT_W-1:0]   r_sat;
  logic               r_done;

  logic [Q_W-1:0]     w_q [LANES];
  logic [LANES-1:0]   w_sat;
  logic [SAT_W-1:0]   w_sat_cnt;
  logic               w_capture;
  logic               w_beat;
  logic               w_is_last;

  // Per-lane requantisers, all evaluated every cycle on the live input.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_clamp #(
      .ZP      (ZP),
      .RELU_EN (RELU_EN)
    ) u_lane_clamp (
      .i_pq  (pq_vec[ACC_W*g +: ACC_W]),
      .o_q   (w_q[g]),
      .o_sat (w_sat[g])
    );
  end

  // Count the lanes that clamped in the vector currently on the input.
  always_comb begin
    w_sat_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sat_cnt = w_sat_cnt + SAT_W'(w_sat[i]);
    end
  end

  // Handshake qualifiers; drain_clr masks both capture and beats.
  always_comb begin
    w_is_last = (r_idx == IDX_W'(LANES - 1));
    w_capture = (r_state == ST_IDLE)  && cap_valid && !drain_clr;
    w_beat    = (r_state == ST_DRAIN) && out_ready && !drain_clr;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: capture enters DRAIN, final beat or abort returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    if (drain_clr) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (cap_valid)               w_next_state = ST_DRAIN;
        ST_DRAIN: if (out_ready && w_is_last)  w_next_state = ST_IDLE;
        default:                               w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs, decoded from registered state only.
  always_comb begin
    cap_ready = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DRAIN);
    out_last  = (r_state == ST_DRAIN) && w_is_last;
    out_data  = (r_state == ST_DRAIN) ? r_buf[r_idx] : '0;
    done      = r_done;
    sat_count = r_sat;
  end

  // Datapath: buffer and saturation count load on capture, index walks on beats.
  always_ff @(posedge clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_idx  <= '0;
      r_sat  <= '0;
      r_done <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_done <= w_beat && w_is_last;
      if (drain_clr) begin
        r_idx <= '0;
      end else if (w_capture) begin
        r_idx <= '0;
        r_sat <= w_sat_cnt;
        for (int i = 0; i < LANES; i++) begin
          r_buf[i] <= w_q[i];
        end
      end else if (w_beat) begin
        r_idx <= w_is_last ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

endmodule
